// File: rtl/power_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : power_seq_ctrl_if
//  Description : Request, power-good and enable/status bundle for the
//                board power-rail sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface power_seq_ctrl_if #(
    parameter int RAIL_NUM = 4,
    parameter int IDX_W    = 2
);
    logic                pwr_on_req_i;
    logic                fault_clr_i;
    logic [RAIL_NUM-1:0] pg_i;
    logic [RAIL_NUM-1:0] en_o;
    logic                pwr_ok_o;
    logic                fault_o;
    logic [IDX_W-1:0]    fault_rail_o;

    // System side: requests power, reports power-good, observes status
    modport master (
        output pwr_on_req_i,
        output fault_clr_i,
        output pg_i,
        input  en_o,
        input  pwr_ok_o,
        input  fault_o,
        input  fault_rail_o
    );

    // Sequencer side
    modport slave (
        input  pwr_on_req_i,
        input  fault_clr_i,
        input  pg_i,
        output en_o,
        output pwr_ok_o,
        output fault_o,
        output fault_rail_o
    );
endinterface
`default_nettype wire

// File: rtl/power_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : power_seq_ctrl
//  Description : Enables RAIL_NUM power rails in order (rail 0 first), waits
//                for each power-good plus a settle gap, disables in reverse
//                order and latches a fault on timeout or power-good loss.
//                pg_i is already synchronized upstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module power_seq_ctrl #(
    parameter int RAIL_NUM    = 4,
    parameter int GAP_CNT     = 1000,
    parameter int TIMEOUT_CNT = 100000,
    parameter int CNT_W       = 17,
    parameter int IDX_W       = 2
) (
    input  logic            clk_i,
    input  logic            rst_n,
    power_seq_ctrl_if.slave bus
);
    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_en_rail  = 4'd1;
    localparam logic [3:0] c_st_wait_pg  = 4'd2;
    localparam logic [3:0] c_st_settle   = 4'd3;
    localparam logic [3:0] c_st_on       = 4'd4;
    localparam logic [3:0] c_st_off_rail = 4'd5;
    localparam logic [3:0] c_st_off_wait = 4'd6;
    localparam logic [3:0] c_st_fault    = 4'd7;

    localparam logic [CNT_W-1:0] c_gap_last     = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CNT - 1);
    localparam logic [CNT_W-1:0] c_timer_max    = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] c_idx_last     = IDX_W'(RAIL_NUM - 1);

    logic [3:0]          r_state,      w_state_nxt;
    logic [IDX_W-1:0]    r_idx,        w_idx_nxt;
    logic [CNT_W-1:0]    r_timer,      w_timer_nxt;
    logic [RAIL_NUM-1:0] r_en,         w_en_nxt;
    logic                r_pwr_ok,     w_pwr_ok_nxt;
    logic                r_fault,      w_fault_nxt;
    logic [IDX_W-1:0]    r_fault_rail, w_fault_rail_nxt;

    logic [CNT_W-1:0]    w_timer_inc;
    logic [RAIL_NUM-1:0] w_drop_vec;
    logic                w_any_drop;
    logic [IDX_W-1:0]    w_drop_idx;
    logic                w_pg_cur;

    // Saturating increment so a stuck state never wraps the timer
    assign w_timer_inc = (r_timer == c_timer_max) ? r_timer : r_timer + 1'b1;
    assign w_pg_cur    = bus.pg_i[r_idx];
    // A rail that is enabled but has lost power-good
    assign w_drop_vec  = r_en & ~bus.pg_i;
    assign w_any_drop  = |w_drop_vec;

    // Lowest-numbered rail that lost power-good wins the fault report
    always_comb begin
        w_drop_idx = '0;
        for (int i = RAIL_NUM - 1; i >= 0; i--) begin
            if (w_drop_vec[i]) begin
                w_drop_idx = IDX_W'(i);
            end
        end
    end

    // State, index, timer and registered outputs; reset drops all enables at once
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_idx        <= '0;
            r_timer      <= '0;
            r_en         <= '0;
            r_pwr_ok     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_rail <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_timer      <= w_timer_nxt;
            r_en         <= w_en_nxt;
            r_pwr_ok     <= w_pwr_ok_nxt;
            r_fault      <= w_fault_nxt;
            r_fault_rail <= w_fault_rail_nxt;
        end
    end

    // Sequencing decisions; timeout outranks an abort on the same edge
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        case (r_state)
            c_st_idle: begin
                if (bus.pwr_on_req_i) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = c_st_en_rail;
                end
            end
            c_st_en_rail: begin
                w_timer_nxt = '0;
                w_state_nxt = bus.pwr_on_req_i ? c_st_wait_pg : c_st_off_rail;
            end
            c_st_wait_pg: begin
                if (!w_pg_cur && (r_timer == c_timeout_last)) begin
                    w_state_nxt = c_st_fault;
                end else if (!bus.pwr_on_req_i) begin
                    w_state_nxt = c_st_off_rail;
                end else if (w_pg_cur) begin
                    w_timer_nxt = '0;
                    w_state_nxt = c_st_settle;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            c_st_settle: begin
                if (!bus.pwr_on_req_i) begin
                    w_state_nxt = c_st_off_rail;
                end else if (r_timer == c_gap_last) begin
                    w_timer_nxt = '0;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = c_st_on;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = c_st_en_rail;
                    end
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            c_st_on: begin
                if (w_any_drop) begin
                    w_state_nxt = c_st_fault;
                end else if (!bus.pwr_on_req_i) begin
                    w_idx_nxt   = c_idx_last;
                    w_state_nxt = c_st_off_rail;
                end
            end
            c_st_off_rail: begin
                w_timer_nxt = '0;
                w_state_nxt = c_st_off_wait;
            end
            c_st_off_wait: begin
                if (r_timer == c_gap_last) begin
                    w_timer_nxt = '0;
                    if (r_idx == '0) begin
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_idx_nxt   = r_idx - 1'b1;
                        w_state_nxt = c_st_off_rail;
                    end
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            c_st_fault: begin
                if (bus.fault_clr_i && !bus.pwr_on_req_i) begin
                    w_idx_nxt   = '0;
                    w_timer_nxt = '0;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_idx_nxt   = '0;
                w_timer_nxt = '0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the transition taken
    always_comb begin
        w_en_nxt         = r_en;
        w_fault_nxt      = r_fault;
        w_fault_rail_nxt = r_fault_rail;
        w_pwr_ok_nxt     = (w_state_nxt == c_st_on);
        case (r_state)
            c_st_en_rail: begin
                if (w_state_nxt == c_st_wait_pg) begin
                    w_en_nxt[r_idx] = 1'b1;
                end
            end
            c_st_off_rail: begin
                w_en_nxt[r_idx] = 1'b0;
            end
            c_st_fault: begin
                w_en_nxt = '0;
                if (w_state_nxt == c_st_idle) begin
                    w_fault_nxt      = 1'b0;
                    w_fault_rail_nxt = '0;
                end
            end
            c_st_idle, c_st_wait_pg, c_st_settle, c_st_on, c_st_off_wait: begin
            end
            default: begin
                w_en_nxt = '0;
            end
        endcase
        // Fault entry removes every enable on the same edge
        if ((w_state_nxt == c_st_fault) && (r_state != c_st_fault)) begin
            w_en_nxt         = '0;
            w_fault_nxt      = 1'b1;
            w_fault_rail_nxt = (r_state == c_st_on) ? w_drop_idx : r_idx;
        end
    end

    assign bus.en_o         = r_en;
    assign bus.pwr_ok_o     = r_pwr_ok;
    assign bus.fault_o      = r_fault;
    assign bus.fault_rail_o = r_fault_rail;

endmodule
`default_nettype wire

// File: tb/tb_power_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_power_seq_ctrl
//  Description : Self-checking bench for power_seq_ctrl (3 rails, gap 4,
//                timeout 8). Expected enable transitions are queued with
//                their cycle numbers and matched as en_o changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_power_seq_ctrl;
    localparam int RAIL_NUM    = 3;
    localparam int GAP_CNT     = 4;
    localparam int TIMEOUT_CNT = 8;
    localparam int CNT_W       = 4;
    localparam int IDX_W       = 2;

    logic clk_i = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int                  exp_cyc[$];
    logic [RAIL_NUM-1:0] exp_en[$];
    logic [RAIL_NUM-1:0] prev_en = '0;
    logic [RAIL_NUM-1:0] force_low = '0;
    int                  age[RAIL_NUM];
    logic [RAIL_NUM-1:0] mon_e;
    int                  mon_c;

    power_seq_ctrl_if #(.RAIL_NUM(RAIL_NUM), .IDX_W(IDX_W)) bus ();

    power_seq_ctrl #(
        .RAIL_NUM    (RAIL_NUM),
        .GAP_CNT     (GAP_CNT),
        .TIMEOUT_CNT (TIMEOUT_CNT),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Edge counter: after edge n, cyc == n
    always @(posedge clk_i) cyc <= cyc + 1;

    // Rail model: power-good rises a little over 2 cycles after its enable
    initial begin : pg_model
        for (int i = 0; i < RAIL_NUM; i++) age[i] = 0;
        bus.pg_i = '0;
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < RAIL_NUM; i++) begin
                if (bus.en_o[i] === 1'b1) begin
                    if (age[i] < 3) age[i] = age[i] + 1;
                end else begin
                    age[i] = 0;
                end
                bus.pg_i[i] = (age[i] >= 3) && !force_low[i];
            end
        end
    end

    // Scoreboard: every change of en_o must match the next queued expectation
    initial begin : en_monitor
        forever begin
            @(negedge clk_i);
            if (bus.en_o !== prev_en) begin
                n_tests++;
                if (exp_en.size() == 0) begin
                    n_fail++;
                    $display("FAIL en_unexpected: en_o=%b at cycle %0d, no change expected", bus.en_o, cyc);
                end else begin
                    mon_e = exp_en.pop_front();
                    mon_c = exp_cyc.pop_front();
                    if (bus.en_o !== mon_e || cyc != mon_c) begin
                        n_fail++;
                        $display("FAIL en_seq: got en_o=%b at cycle %0d, expected %b at cycle %0d",
                                 bus.en_o, cyc, mon_e, mon_c);
                    end
                end
                prev_en = bus.en_o;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_en(input int c, input logic [RAIL_NUM-1:0] v);
        exp_cyc.push_back(c);
        exp_en.push_back(v);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget && exp_en.size() != 0; k++) tick();
        n_tests++;
        if (exp_en.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d enable changes still pending, expected 0", name, exp_en.size());
            exp_en.delete();
            exp_cyc.delete();
        end
    endtask

    task automatic wait_pwr_ok(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (bus.pwr_ok_o === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.pwr_on_req_i = 1'b0;
        bus.fault_clr_i  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_tests++; if (bus.en_o !== 3'b000) begin n_fail++; $display("FAIL reset_en: got %b, expected 000", bus.en_o); end
        n_tests++; if (bus.pwr_ok_o !== 1'b0) begin n_fail++; $display("FAIL reset_pwr_ok: got %b, expected 0", bus.pwr_ok_o); end
        n_tests++; if (bus.fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b, expected 0", bus.fault_o); end
        n_tests++; if (bus.fault_rail_o !== 2'd0) begin n_fail++; $display("FAIL reset_fault_rail: got %0d, expected 0", bus.fault_rail_o); end
        rst_n = 1'b1;
        tick(); tick();
        n_tests++; if (bus.en_o !== 3'b000) begin n_fail++; $display("FAIL idle_en: got %b, expected 000", bus.en_o); end
    endtask

    task automatic test_power_up();
        int c, at;
        tick();
        c = cyc;
        bus.pwr_on_req_i = 1'b1;
        expect_en(c + 2,  3'b001);
        expect_en(c + 10, 3'b011);
        expect_en(c + 18, 3'b111);
        wait_pwr_ok(60, at);
        n_tests++; if (at != c + 25) begin n_fail++; $display("FAIL up_pwr_ok_cycle: got %0d, expected %0d", at, c + 25); end
        n_tests++; if (bus.fault_o !== 1'b0) begin n_fail++; $display("FAIL up_fault: got %b, expected 0", bus.fault_o); end
        wait_drain("up", 5);
    endtask

    task automatic test_power_down();
        int c, d, at;
        tick();
        c = cyc;
        d = c + 1;
        bus.pwr_on_req_i = 1'b0;
        expect_en(d + 1,  3'b011);
        expect_en(d + 6,  3'b001);
        expect_en(d + 11, 3'b000);
        expect_en(d + 17, 3'b001);
        expect_en(d + 25, 3'b011);
        expect_en(d + 33, 3'b111);
        tick();
        n_tests++; if (bus.pwr_ok_o !== 1'b0) begin n_fail++; $display("FAIL down_pwr_ok: got %b, expected 0", bus.pwr_ok_o); end
        tick();
        bus.pwr_on_req_i = 1'b1;   // re-request while en_o=011: held off until IDLE
        wait_pwr_ok(80, at);
        n_tests++; if (at != d + 40) begin n_fail++; $display("FAIL down_restart_pwr_ok_cycle: got %0d, expected %0d", at, d + 40); end
        wait_drain("down", 5);
    endtask

    task automatic test_pg_drop();
        int c;
        tick();
        c = cyc;
        force_low = 3'b101;
        expect_en(c + 1, 3'b000);
        tick();
        n_tests++; if (bus.fault_o !== 1'b1) begin n_fail++; $display("FAIL drop_fault: got %b, expected 1", bus.fault_o); end
        n_tests++; if (bus.fault_rail_o !== 2'd0) begin n_fail++; $display("FAIL drop_fault_rail: got %0d, expected 0", bus.fault_rail_o); end
        n_tests++; if (bus.pwr_ok_o !== 1'b0) begin n_fail++; $display("FAIL drop_pwr_ok: got %b, expected 0", bus.pwr_ok_o); end
        bus.fault_clr_i = 1'b1;
        tick();
        bus.fault_clr_i = 1'b0;
        tick();
        n_tests++; if (bus.fault_o !== 1'b1) begin n_fail++; $display("FAIL drop_clr_ignored: got %b, expected 1", bus.fault_o); end
        bus.pwr_on_req_i = 1'b0;
        bus.fault_clr_i  = 1'b1;
        tick();
        bus.fault_clr_i  = 1'b0;
        n_tests++; if (bus.fault_o !== 1'b0) begin n_fail++; $display("FAIL drop_clr_fault: got %b, expected 0", bus.fault_o); end
        n_tests++; if (bus.fault_rail_o !== 2'd0) begin n_fail++; $display("FAIL drop_clr_rail: got %0d, expected 0", bus.fault_rail_o); end
        force_low = '0;
        wait_drain("drop", 5);
    endtask

    task automatic test_timeout();
        int c, at;
        force_low = 3'b010;
        tick();
        c = cyc;
        bus.pwr_on_req_i = 1'b1;
        expect_en(c + 2,  3'b001);
        expect_en(c + 10, 3'b011);
        expect_en(c + 18, 3'b000);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.fault_o === 1'b1) begin
                at = cyc;
                break;
            end
        end
        n_tests++; if (at != c + 18) begin n_fail++; $display("FAIL timeout_cycle: got %0d, expected %0d", at, c + 18); end
        n_tests++; if (bus.fault_rail_o !== 2'd1) begin n_fail++; $display("FAIL timeout_rail: got %0d, expected 1", bus.fault_rail_o); end
        n_tests++; if (bus.en_o !== 3'b000) begin n_fail++; $display("FAIL timeout_en: got %b, expected 000", bus.en_o); end
        repeat (10) tick();
        n_tests++; if (bus.fault_o !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: got %b, expected 1", bus.fault_o); end
        bus.pwr_on_req_i = 1'b0;
        bus.fault_clr_i  = 1'b1;
        tick();
        bus.fault_clr_i  = 1'b0;
        n_tests++; if (bus.fault_o !== 1'b0) begin n_fail++; $display("FAIL timeout_clr: got %b, expected 0", bus.fault_o); end
        wait_drain("timeout", 5);
    endtask

    task automatic test_abort();
        int c;
        force_low = 3'b010;
        tick();
        c = cyc;
        bus.pwr_on_req_i = 1'b1;
        expect_en(c + 2,  3'b001);
        expect_en(c + 10, 3'b011);
        expect_en(c + 14, 3'b001);
        expect_en(c + 19, 3'b000);
        repeat (12) tick();
        bus.pwr_on_req_i = 1'b0;   // sampled while still waiting for rail 1
        repeat (12) tick();
        n_tests++; if (bus.fault_o !== 1'b0) begin n_fail++; $display("FAIL abort_fault: got %b, expected 0", bus.fault_o); end
        n_tests++; if (bus.en_o !== 3'b000) begin n_fail++; $display("FAIL abort_en: got %b, expected 000", bus.en_o); end
        wait_drain("abort", 5);
        force_low = '0;
    endtask

    task automatic test_reset_mid();
        int c, r, at;
        tick();
        c = cyc;
        bus.pwr_on_req_i = 1'b1;
        expect_en(c + 2,  3'b001);
        expect_en(c + 10, 3'b011);
        expect_en(c + 18, 3'b111);
        wait_pwr_ok(60, at);
        n_tests++; if (at != c + 25) begin n_fail++; $display("FAIL rst_up_cycle: got %0d, expected %0d", at, c + 25); end
        wait_drain("rst_up", 5);
        expect_en(cyc, 3'b000);
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.en_o !== 3'b000) begin n_fail++; $display("FAIL rst_async_en: got %b, expected 000", bus.en_o); end
        n_tests++; if (bus.pwr_ok_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_pwr_ok: got %b, expected 0", bus.pwr_ok_o); end
        tick(); tick();
        r = cyc;
        rst_n = 1'b1;              // request still high: IDLE restarts at rail 0
        expect_en(r + 2, 3'b001);
        expect_en(r + 4, 3'b000);
        tick(); tick();
        bus.pwr_on_req_i = 1'b0;
        wait_drain("rst_restart", 20);
        n_tests++; if (bus.fault_o !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b, expected 0", bus.fault_o); end
    endtask

    initial begin : main
        test_reset();
        test_power_up();
        test_power_down();
        test_pg_drop();
        test_timeout();
        test_abort();
        test_reset_mid();
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/power_seq_ctrl.md
Name: power_seq_ctrl

Overview:
- Drives the enable pins of RAIL_NUM board power rails in a fixed order and checks each rail's power-good before enabling the next.
- Powers down in reverse order.
- Latches a fault, removing all enables at once, on power-good timeout or on loss of power-good while on.
- Sits in power_monitor_top; pg_i comes from per-rail power_state synchronizers, so no extra synchronization is done here.

Parameters:
- RAIL_NUM, 4, number of rails; rail 0 is enabled first and disabled last.
- GAP_CNT, 1000, settle cycles after a rail's power-good before the next rail is enabled; also the delay between rail disables on power-down.
- TIMEOUT_CNT, 100000, maximum cycles to wait for power-good after an enable.
- CNT_W, 17, timer width; must satisfy 2^CNT_W > max(GAP_CNT, TIMEOUT_CNT).
- IDX_W, 2, rail index width; must satisfy 2^IDX_W >= RAIL_NUM.

Ports:
- clk_i, input, 1, system clock; all logic is on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pwr_on_req_i, input, 1, level request: 1 = power up, 0 = power down.
- fault_clr_i, input, 1, one-cycle pulse that clears a latched fault.
- pg_i, input, RAIL_NUM, synchronized power-good per rail.
- en_o, output, RAIL_NUM, registered rail enables.
- pwr_ok_o, output, 1, registered; high only in state ON.
- fault_o, output, 1, registered latched fault flag.
- fault_rail_o, output, IDX_W, index of the faulting rail.

Behaviour:
- Reset: en_o=0, pwr_ok_o=0, fault_o=0, fault_rail_o=0, idx=0, timer=0, state=IDLE.
- All outputs are registered and change only on clk_i edges.
- IDLE
  - If pwr_on_req_i=1: set idx=0 and go to EN_RAIL.
- EN_RAIL
  - Set en_o[idx]=1, clear timer, go to WAIT_PG.
  - Latency: request sampled high at edge k gives en_o[0]=1 after edge k+1.
- WAIT_PG
  - If pg_i[idx]=1: clear timer, go to SETTLE.
  - Else if timer==TIMEOUT_CNT-1: go to FAULT.
  - Else: timer+1.
- SETTLE
  - Timer counts from 0 to GAP_CNT-1.
  - At terminal count: if idx==RAIL_NUM-1 go to ON; else idx+1 and go to EN_RAIL.
- ON
  - pwr_ok_o=1.
  - If any pg_i[i]=0 (with en_o[i]=1): go to FAULT with fault_rail_o = lowest such i.
  - Else if pwr_on_req_i=0: set idx=RAIL_NUM-1 and go to OFF_RAIL. pwr_ok_o drops on the same edge.
- Abort during power-up
  - pwr_on_req_i=0 in EN_RAIL, WAIT_PG or SETTLE: keep idx and go to OFF_RAIL.
  - Only the rails already enabled are sequenced off.
  - A timeout fault reached on the same edge takes priority over the abort.
- OFF_RAIL
  - Set en_o[idx]=0, clear timer, go to OFF_WAIT.
- OFF_WAIT
  - Count GAP_CNT cycles, then: if idx==0 go to IDLE; else idx-1 and go to OFF_RAIL.
  - pg_i is ignored during power-down.
  - pwr_on_req_i re-asserted during power-down is ignored until IDLE is reached; no restart mid-sequence.
- FAULT
  - On entry: en_o=0 (all rails on the same edge), fault_o=1, pwr_ok_o=0, fault_rail_o=idx for a timeout.
  - Exit to IDLE only when fault_clr_i=1 and pwr_on_req_i=0 are sampled together; this clears fault_o, fault_rail_o, idx and timer.
  - fault_clr_i while pwr_on_req_i=1 is ignored.
  - fault_clr_i in any other state has no effect.
- Simultaneous events in ON: a pg drop and a request drop in the same cycle go to FAULT.
- Timer saturates; it never wraps.
- Undefined FSM encodings recover to IDLE with en_o=0.
- Reset mid-sequence forces all enables to 0 asynchronously, with no reverse sequencing.

Test Plan:
- RAIL_NUM=3, GAP_CNT=4, TIMEOUT_CNT=8. Assert req, tie each pg high 2 cycles after its enable -> en_o goes 001, 011, 111. Each enable rises 2+1+4+1 cycles after the previous one. pwr_ok_o=1 after the last rail settles.
- From ON, deassert req -> pwr_ok_o=0 on the next edge. en_o goes 011, 001, 000 with 5-cycle spacing, then IDLE. Re-asserting req at en_o=011 has no effect until IDLE.
- Hold pg_i[1]=0 after en_o=011 -> exactly 8 cycles in WAIT_PG, then en_o=000, fault_o=1, fault_rail_o=1. A later req=1 does nothing.
- In ON, drop pg_i[2] and pg_i[0] together -> FAULT with fault_rail_o=0. fault_clr_i with req=1 is ignored. fault_clr_i with req=0 -> fault_o=0, state IDLE.
- Deassert req while waiting for pg_i[1] -> rail 1, then rail 0 turn off at 5-cycle spacing. en_o[2] never asserts. No fault.
- Pulse rst_n low with en_o=111 -> en_o=000 and pwr_ok_o=0 immediately, before the next edge. The FSM is in IDLE after release.
